// File: rtl/minialu_seq.sv
// minialu_seq_top: sequential switch-driven mini ALU for the lab board.
// The operator enters A, then B with op/sign, using the switches and the enter key.
// Add/sub take one EXEC cycle. Multiply (shift-add) and divide (restoring) take
// OP_WIDTH EXEC cycles. The result is shown in hex on seven-segment digits.
// Ports:
//   clk, rst          - board clock; asynchronous active-high reset
//   switches          - [SW-1:3] operand, [2:1] op (add/sub/mul/div), [0] signed mode
//   enter             - debounced, synchronised key level
//   leds              - {busy, div0 error, negative, state[1:0], 5'b0}
//   displayBits       - active-low segments {dp,g,f,e,d,c,b,a}; digit 0 is rightmost
module minialu_seq_top #(
  parameter int SW_WIDTH   = 10,
  parameter int NUM_DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                enter,
  output logic [9:0]          leds,
  output logic [7:0]          displayBits [0:NUM_DIGITS-1]
);

  localparam int OP_WIDTH  = SW_WIDTH - 3;
  localparam int RES_WIDTH = 2 * OP_WIDTH;
  localparam int CNT_W     = $clog2(OP_WIDTH);
  localparam int HEXD      = NUM_DIGITS - 1;      // digits carrying the result
  localparam int HEX_BITS  = 4 * HEXD;
  localparam int OPD       = (OP_WIDTH + 3) / 4;  // digits carrying a live operand
  localparam int OPV_BITS  = 4 * OPD;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    EXEC  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic                   enter_q, enter_d;
  logic [OP_WIDTH-1:0]    a_q, a_d;
  logic [OP_WIDTH-1:0]    b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic                   sign_q, sign_d;
  logic [RES_WIDTH-1:0]   res_q, res_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RES_WIDTH-1:0]   acc_q, acc_d;   // multiply accumulator
  logic [OP_WIDTH-1:0]    rem_q, rem_d;   // divide partial remainder
  logic [OP_WIDTH-1:0]    quo_q, quo_d;   // dividend shifts out as quotient shifts in

  function automatic logic [OP_WIDTH-1:0] mag_of(input logic [OP_WIDTH-1:0] v,
                                                 input logic s);
    return (s && v[OP_WIDTH-1]) ? (OP_WIDTH'(0) - v) : v;
  endfunction

  function automatic logic [7:0] seg_hex(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  logic [OP_WIDTH-1:0]  operand;
  logic                 press;
  logic [OP_WIDTH-1:0]  mag_a, mag_b;
  logic                 res_neg;
  logic [RES_WIDTH-1:0] ext_a, ext_b;
  logic                 last_iter;
  logic [RES_WIDTH-1:0] partial, acc_nx;
  logic [OP_WIDTH:0]    rem_shift;
  logic                 q_bit;
  logic [OP_WIDTH-1:0]  rem_nx, quo_nx;

  assign operand = switches[SW_WIDTH-1:3];
  assign press   = enter & ~enter_q;

  // Datapath helpers driven only by registered operands
  always_comb begin
    mag_a     = mag_of(a_q, sign_q);
    mag_b     = mag_of(b_q, sign_q);
    res_neg   = sign_q & (a_q[OP_WIDTH-1] ^ b_q[OP_WIDTH-1]);
    ext_a     = sign_q ? {{OP_WIDTH{a_q[OP_WIDTH-1]}}, a_q} : {{OP_WIDTH{1'b0}}, a_q};
    ext_b     = sign_q ? {{OP_WIDTH{b_q[OP_WIDTH-1]}}, b_q} : {{OP_WIDTH{1'b0}}, b_q};
    last_iter = (cnt_q == CNT_W'(OP_WIDTH - 1));

    // Shift-add: bit cnt of |B| selects |A| << cnt
    partial   = RES_WIDTH'(mag_a) << cnt_q;
    acc_nx    = mag_b[cnt_q] ? (acc_q + partial) : acc_q;

    // Restoring divide: bring down the next dividend bit, subtract if it fits
    rem_shift = {rem_q, quo_q[OP_WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, mag_b});
    rem_nx    = q_bit ? OP_WIDTH'(rem_shift - {1'b0, mag_b}) : OP_WIDTH'(rem_shift);
    quo_nx    = {quo_q[OP_WIDTH-2:0], q_bit};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    enter_d = enter;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sign_d  = sign_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;

    case (state_q)
      GET_A: begin
        if (press) begin
          a_d     = operand;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (press) begin
          b_d     = operand;
          op_d    = switches[2:1];
          sign_d  = switches[0];
          acc_d   = '0;
          rem_d   = '0;
          // Sign mode is latched on this same edge, so use the live bit
          quo_d   = mag_of(a_q, switches[0]);
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          2'b00: begin
            res_d   = ext_a + ext_b;
            state_d = DONE;
          end
          2'b01: begin
            res_d   = ext_a - ext_b;
            state_d = DONE;
          end
          2'b10: begin
            acc_d = acc_nx;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
              res_d   = res_neg ? (RES_WIDTH'(0) - acc_nx) : acc_nx;
              state_d = DONE;
            end
          end
          default: begin
            if (b_q == '0) begin
              res_d   = '0;
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              rem_d = rem_nx;
              quo_d = quo_nx;
              cnt_d = cnt_q + CNT_W'(1);
              if (last_iter) begin
                res_d   = res_neg ? (RES_WIDTH'(0) - RES_WIDTH'(quo_nx)) : RES_WIDTH'(quo_nx);
                state_d = DONE;
              end
            end
          end
        endcase
      end
      default: begin  // DONE
        if (press) begin
          a_d     = operand;
          err_d   = 1'b0;
          state_d = GET_B;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      enter_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
    end
  end

  // Output decode of registered state
  logic                 neg;
  logic [RES_WIDTH-1:0] disp_mag;
  logic [HEX_BITS-1:0]  mag_ext;
  logic [OPV_BITS-1:0]  op_view;

  always_comb begin
    neg      = (state_q == DONE) & sign_q & res_q[RES_WIDTH-1];
    disp_mag = neg ? (RES_WIDTH'(0) - res_q) : res_q;
    mag_ext  = HEX_BITS'(disp_mag);
    op_view  = OPV_BITS'(operand);

    leds      = '0;
    leds[9]   = (state_q == EXEC);
    leds[8]   = err_q;
    leds[7]   = neg;
    leds[6:5] = state_q;

    for (int i = 0; i < NUM_DIGITS; i++) displayBits[i] = SEG_BLANK;

    case (state_q)
      GET_A, GET_B: begin
        for (int i = 0; i < OPD; i++) displayBits[i] = seg_hex(op_view[4*i +: 4]);
      end
      DONE: begin
        if (err_q) begin
          for (int i = 0; i < NUM_DIGITS; i++) displayBits[i] = SEG_DASH;
        end else begin
          for (int i = 0; i < HEXD; i++) displayBits[i] = seg_hex(mag_ext[4*i +: 4]);
          displayBits[NUM_DIGITS-1] = neg ? SEG_DASH : SEG_BLANK;
        end
      end
      default: ;  // EXEC stays blank
    endcase
  end

endmodule

// File: tb/tb_minialu_seq_top.sv
module tb_minialu_seq_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] switches = '0;
  logic       enter = 1'b0;
  logic [9:0] leds;
  logic [7:0] disp [0:5];

  int n_vec = 0;
  int n_bad = 0;

  minialu_seq_top dut (
    .clk         (clk),
    .rst         (rst),
    .switches    (switches),
    .enter       (enter),
    .leds        (leds),
    .displayBits (disp)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [6:0]  a;
    logic [6:0]  b;
    logic [1:0]  op;
    logic        s;
    logic [47:0] disp;
    logic [9:0]  leds;
    int          busy;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [47:0] disp_packed();
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = disp[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: arithmetic on plain integers, then formatted for the board
  task automatic model(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op,
                       input logic s, output logic [47:0] e_disp, output logic [9:0] e_leds,
                       output int e_busy);
    int va, vb, r, res14, mag;
    bit err, neg;
    va = int'(a);
    vb = int'(b);
    if (s && a[6]) va -= 128;
    if (s && b[6]) vb -= 128;
    err = (op == 2'b11) && (vb == 0);
    case (op)
      2'b00:   r = va + vb;
      2'b01:   r = va - vb;
      2'b10:   r = va * vb;
      default: r = err ? 0 : va / vb;
    endcase
    res14 = r & 32'h3FFF;
    neg   = s && (res14 >= 8192);
    mag   = neg ? 16384 - res14 : res14;
    for (int i = 0; i < 5; i++) e_disp[8*i +: 8] = GLYPH[(mag >> (4*i)) & 15];
    e_disp[47:40] = neg ? 8'hBF : 8'hFF;
    if (err) e_disp = {6{8'hBF}};
    e_leds = {1'b0, err, neg, 2'b11, 5'b0};
    e_busy = (op[1] && !err) ? 7 : 1;
  endtask

  // Enter A (unless skipped), then B/op/sign, and count busy cycles until DONE.
  task automatic do_op(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op,
                       input logic s, input bit skip_a, input bit poke, input int abort_at,
                       output int busy, output bit timeout);
    enter = 1'b0;
    tick();
    if (!skip_a) begin
      switches = {a, 3'b000};
      enter = 1'b1; tick();
      enter = 1'b0; tick();
    end
    switches = {b, op, s};
    enter = 1'b1; tick();
    enter = 1'b0;
    busy = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (leds[6:5] == 2'b11) begin timeout = 1'b0; break; end
      if (leds[9]) busy++;
      if (abort_at != 0 && busy == abort_at) begin
        rst = 1'b1;
        #2;
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (poke) enter = ~enter;
    end
    enter = 1'b0;
  endtask

  task automatic apply(input string nm, input logic [6:0] a, input logic [6:0] b,
                       input logic [1:0] op, input logic s, input bit skip_a, input bit poke,
                       input logic [47:0] e_disp, input logic [9:0] e_leds, input int e_busy);
    int  busy;
    bit  to;
    do_op(a, b, op, s, skip_a, poke, 0, busy, to);
    chk({nm, ".done"}, 64'(to), 64'(0));
    chk({nm, ".disp"}, 64'(disp_packed()), 64'(e_disp));
    chk({nm, ".leds"}, 64'(leds), 64'(e_leds));
    chk({nm, ".busy"}, 64'(busy), 64'(e_busy));
  endtask

  initial begin
    logic [47:0] e_disp;
    logic [9:0]  e_leds;
    int          e_busy, busy;
    bit          to;
    logic [6:0]  ra, rb;
    logic [1:0]  rop;
    logic        rs;

    tbl[0] = '{7'd5,   7'd3,   2'b00, 1'b0, 48'hFFC0C0C0C080, 10'h060, 1};
    tbl[1] = '{7'd3,   7'd5,   2'b01, 1'b0, 48'hFFC0B08E8E86, 10'h060, 1};
    tbl[2] = '{7'd3,   7'd5,   2'b01, 1'b1, 48'hBFC0C0C0C0A4, 10'h0E0, 1};
    tbl[3] = '{7'h7D,  7'd5,   2'b10, 1'b1, 48'hBFC0C0C0C08E, 10'h0E0, 7};
    tbl[4] = '{7'd127, 7'd127, 2'b10, 1'b0, 48'hFFC0B08EC0F9, 10'h060, 7};
    tbl[5] = '{7'd100, 7'd7,   2'b11, 1'b0, 48'hFFC0C0C0C086, 10'h060, 7};
    tbl[6] = '{7'h40,  7'h7F,  2'b11, 1'b1, 48'hFFC0C0C099C0, 10'h060, 7};
    tbl[7] = '{7'd9,   7'd0,   2'b11, 1'b0, 48'hBFBFBFBFBFBF, 10'h160, 1};
    tbl[8] = '{7'd7,   7'h7E,  2'b11, 1'b1, 48'hBFC0C0C0C0B0, 10'h0E0, 7};

    // Reset: GET_A, LEDs dark, live operand 0x2A shown on the low two digits
    switches = {7'h2A, 3'b000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.leds_in_reset", 64'(leds), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset.leds", 64'(leds), 64'(0));
    chk("reset.disp", 64'(disp_packed()), 64'(48'hFFFFFFFFA488));

    // Holding enter for 20 cycles yields exactly one press
    switches = {7'h11, 3'b000};
    @(posedge clk); #1;
    enter = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("hold.state", 64'(leds), 64'(10'h020));
    model(7'h11, 7'd3, 2'b00, 1'b0, e_disp, e_leds, e_busy);
    apply("hold.add", 7'h11, 7'd3, 2'b00, 1'b0, 1'b1, 1'b0, e_disp, e_leds, e_busy);

    // Directed table
    for (int i = 0; i < 9; i++)
      apply($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].s, 1'b0, 1'b0,
            tbl[i].disp, tbl[i].leds, tbl[i].busy);

    // Presses toggling throughout EXEC are ignored
    apply("poke.mul", 7'h7D, 7'd5, 2'b10, 1'b1, 1'b0, 1'b1, 48'hBFC0C0C0C08E, 10'h0E0, 7);
    apply("poke.div", 7'd100, 7'd7, 2'b11, 1'b0, 1'b0, 1'b1, 48'hFFC0C0C0C086, 10'h060, 7);

    // Asynchronous reset in the 4th multiply cycle
    do_op(7'd6, 7'd5, 2'b10, 1'b0, 1'b0, 1'b0, 4, busy, to);
    chk("abort.reached", 64'(to), 64'(0));
    chk("abort.leds", 64'(leds), 64'(0));
    chk("abort.disp", 64'(disp_packed()), 64'(48'hFFFFFFFFC092));
    #1 rst = 1'b0;
    apply("abort.add", 7'd2, 7'd2, 2'b00, 1'b0, 1'b0, 1'b0, 48'hFFC0C0C0C099, 10'h060, 1);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ra  = 7'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
      rop = 2'($urandom);
      rs  = 1'($urandom);
      model(ra, rb, rop, rs, e_disp, e_leds, e_busy);
      apply($sformatf("rnd%0d", i), ra, rb, rop, rs, 1'b0, 1'b0, e_disp, e_leds, e_busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
